// File: rtl/register_update_pkg.sv
// Shared types and constants for the register update sequencer and its helpers.
package register_update_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam int ERR_COUNT_W = 16;
    localparam logic [ERR_COUNT_W-1:0] ERR_COUNT_MAX = '1;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: the first requesting index after last_chan,
// wrapping around, wins. last_chan itself has the lowest priority.
module rr_priority_picker #(
    parameter int NUM_CHANNELS = 4,
    parameter int CHAN_BITS    = $clog2(NUM_CHANNELS)
) (
    input  logic [NUM_CHANNELS-1:0] req,
    input  logic [CHAN_BITS-1:0]    last_chan,
    output logic                    valid,
    output logic [CHAN_BITS-1:0]    sel
);

    always_comb begin : pick
        int                   idx;
        logic [CHAN_BITS-1:0] cand;
        valid = |req;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        // Walk from the farthest offset down so the nearest requester is written last.
        for (int off = NUM_CHANNELS; off >= 1; off--) begin
            idx = int'(last_chan) + off;
            if (idx >= NUM_CHANNELS) begin
                idx = idx - NUM_CHANNELS;
            end
            cand = CHAN_BITS'(idx);
            if (req[cand]) begin
                sel = cand;
            end
        end
    end

endmodule

// File: rtl/register_update_sequencer.sv
// Coalesces per-channel config updates into shadow registers and issues them
// one at a time, round robin, onto a single register-synchroniser port.
module register_update_sequencer
    import register_update_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int WIDTH        = 48,
    parameter int ACK_TIMEOUT  = 255,
    parameter int CHAN_BITS    = $clog2(NUM_CHANNELS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CHANNELS-1:0]       upd_en,
    input  logic [NUM_CHANNELS*WIDTH-1:0] upd_data,
    output logic                          tx_en,
    output logic [CHAN_BITS-1:0]          tx_chan,
    output logic [WIDTH-1:0]              tx_data,
    input  logic                          tx_ack,
    output logic [NUM_CHANNELS-1:0]       pending,
    output logic                          busy,
    output logic                          err_timeout,
    output logic [ERR_COUNT_W-1:0]        err_count
);

    localparam int TIMER_W = $clog2(ACK_TIMEOUT);
    // Timer is cleared in ISSUE and the error is registered, so the last WAIT_ACK
    // cycle is ACK_TIMEOUT-1 cycles after ISSUE, with the timer at ACK_TIMEOUT-2.
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ACK_TIMEOUT - 2);

    state_t                  state_reg;
    logic [CHAN_BITS-1:0]    sel_reg;
    logic [CHAN_BITS-1:0]    last_chan_reg;
    logic [TIMER_W-1:0]      timer_reg;
    logic [NUM_CHANNELS-1:0] pending_reg;
    logic [NUM_CHANNELS-1:0] pending_next;
    logic                    tx_en_reg;
    logic [WIDTH-1:0]        tx_data_reg;
    logic                    busy_reg;
    logic                    err_timeout_reg;
    logic [ERR_COUNT_W-1:0]  err_count_reg;

    logic [WIDTH-1:0]        shadow   [NUM_CHANNELS];
    logic [WIDTH-1:0]        upd_word [NUM_CHANNELS];
    logic                    pick_valid;
    logic [CHAN_BITS-1:0]    pick_sel;
    logic                    ack_timeout;

    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_shadow
        logic [WIDTH-1:0] value_reg;

        assign upd_word[gi] = upd_data[gi*WIDTH +: WIDTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                value_reg <= '0;
            end else if (upd_en[gi]) begin
                value_reg <= upd_word[gi];
            end
        end

        assign shadow[gi] = value_reg;
    end

    rr_priority_picker #(
        .NUM_CHANNELS(NUM_CHANNELS),
        .CHAN_BITS   (CHAN_BITS)
    ) u_picker (
        .req      (pending_reg),
        .last_chan(last_chan_reg),
        .valid    (pick_valid),
        .sel      (pick_sel)
    );

    // An ack on the expiry cycle wins over the timeout.
    assign ack_timeout = (state_reg == WAIT_ACK) && !tx_ack && (timer_reg == TIMER_LAST);

    always_comb begin
        pending_next = pending_reg | upd_en;
        if (state_reg == ISSUE && !upd_en[sel_reg]) begin
            pending_next[sel_reg] = 1'b0;
        end
        if (ack_timeout) begin
            pending_next[sel_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            sel_reg         <= '0;
            last_chan_reg   <= CHAN_BITS'(NUM_CHANNELS - 1);
            timer_reg       <= '0;
            pending_reg     <= '0;
            tx_en_reg       <= 1'b0;
            tx_data_reg     <= '0;
            busy_reg        <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_count_reg   <= '0;
        end else begin
            tx_en_reg       <= 1'b0;
            err_timeout_reg <= 1'b0;
            pending_reg     <= pending_next;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        state_reg <= ISSUE;
                        sel_reg   <= pick_sel;
                        tx_en_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                        // A strobe landing this cycle is already the newest value; send it.
                        tx_data_reg <= upd_en[pick_sel] ? upd_word[pick_sel] : shadow[pick_sel];
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT_ACK;
                    timer_reg <= '0;
                end
                WAIT_ACK: begin
                    if (tx_ack) begin
                        state_reg     <= IDLE;
                        last_chan_reg <= sel_reg;
                        busy_reg      <= 1'b0;
                    end else if (ack_timeout) begin
                        state_reg       <= IDLE;
                        last_chan_reg   <= sel_reg;
                        busy_reg        <= 1'b0;
                        err_timeout_reg <= 1'b1;
                        if (err_count_reg != ERR_COUNT_MAX) begin
                            err_count_reg <= err_count_reg + 1'b1;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_en       = tx_en_reg;
    assign tx_chan     = sel_reg;
    assign tx_data     = tx_data_reg;
    assign pending     = pending_reg;
    assign busy        = busy_reg;
    assign err_timeout = err_timeout_reg;
    assign err_count   = err_count_reg;

endmodule

// File: tb/tb_register_update_sequencer.sv
// Directed bench: table of single-update vectors plus hand-written sequences for
// coalescing, round robin, in-flight updates, timeout and reset mid-transfer.
module tb_register_update_sequencer;

    logic         clk;
    logic         reset;
    logic [3:0]   upd_en;
    logic [191:0] upd_data;
    logic         tx_ack;

    logic         tx_en_a, tx_en_b;
    logic [1:0]   tx_chan_a, tx_chan_b;
    logic [47:0]  tx_data_a, tx_data_b;
    logic [3:0]   pending_a, pending_b;
    logic         busy_a, busy_b;
    logic         err_timeout_a, err_timeout_b;
    logic [15:0]  err_count_a, err_count_b;

    int checks = 0;
    int errors = 0;

    register_update_sequencer #(
        .NUM_CHANNELS(4), .WIDTH(48), .ACK_TIMEOUT(255)
    ) dut_a (
        .clk(clk), .reset(reset), .upd_en(upd_en), .upd_data(upd_data),
        .tx_en(tx_en_a), .tx_chan(tx_chan_a), .tx_data(tx_data_a), .tx_ack(tx_ack),
        .pending(pending_a), .busy(busy_a), .err_timeout(err_timeout_a),
        .err_count(err_count_a)
    );

    register_update_sequencer #(
        .NUM_CHANNELS(4), .WIDTH(48), .ACK_TIMEOUT(8)
    ) dut_b (
        .clk(clk), .reset(reset), .upd_en(upd_en), .upd_data(upd_data),
        .tx_en(tx_en_b), .tx_chan(tx_chan_b), .tx_data(tx_data_b), .tx_ack(tx_ack),
        .pending(pending_b), .busy(busy_b), .err_timeout(err_timeout_b),
        .err_count(err_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]   mask;
        logic [191:0] data;
        int           ack_delay;
        logic [1:0]   exp_chan;
        logic [47:0]  exp_data;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [191:0] pack4(input logic [47:0] c0, input logic [47:0] c1,
                                           input logic [47:0] c2, input logic [47:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        upd_en = '0;
        tx_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] mask, input logic [191:0] data);
        upd_en   = mask;
        upd_data = data;
        tick();
        upd_en = '0;
    endtask

    task automatic ack_after(input int n);
        repeat (n) tick();
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
    endtask

    task automatic wait_tx(input bit use_b, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = use_b ? tx_en_b : tx_en_a;
        end
        check({name, " tx_en seen"}, 64'(got), 64'd1);
        if (got) begin
            $display("tx %s: chan=%0d data=%h", name,
                     use_b ? tx_chan_b : tx_chan_a, use_b ? tx_data_b : tx_data_a);
        end
    endtask

    task automatic count_tx(input int n, input bit use_b, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (use_b ? tx_en_b : tx_en_a) cnt++;
        end
    endtask

    initial begin
        int cnt;
        upd_data = '0;

        vecs[0] = '{4'b0010, pack4(48'h0A0A, 48'h0200_0000_0001, 48'h0C0C, 48'h0D0D),
                    10, 2'd1, 48'h0200_0000_0001};
        vecs[1] = '{4'b0001, pack4(48'hFFFF_FFFF_FFFF, 48'h1, 48'h2, 48'h3),
                    1, 2'd0, 48'hFFFF_FFFF_FFFF};
        vecs[2] = '{4'b1000, pack4(48'h0, 48'h1, 48'h2, 48'h8000_0000_0000),
                    5, 2'd3, 48'h8000_0000_0000};
        vecs[3] = '{4'b0100, pack4(48'h5, 48'h6, 48'h1234_5678_9ABC, 48'h7),
                    3, 2'd2, 48'h1234_5678_9ABC};

        do_reset();
        check("reset tx_en", 64'(tx_en_a), 64'd0);
        check("reset tx_chan", 64'(tx_chan_a), 64'd0);
        check("reset tx_data", 64'(tx_data_a), 64'd0);
        check("reset pending", 64'(pending_a), 64'd0);
        check("reset busy", 64'(busy_a), 64'd0);
        check("reset err_timeout", 64'(err_timeout_a), 64'd0);
        check("reset err_count", 64'(err_count_a), 64'd0);
        check("reset b busy", 64'(busy_b), 64'd0);

        // Single-update vectors: strobe at cycle 0, pending at 1, tx_en at 2.
        for (int v = 0; v < 4; v++) begin
            do_reset();
            strobe(vecs[v].mask, vecs[v].data);
            check($sformatf("vec%0d pending c1", v), 64'(pending_a), 64'(vecs[v].mask));
            check($sformatf("vec%0d tx_en c1", v), 64'(tx_en_a), 64'd0);
            tick();
            check($sformatf("vec%0d tx_en c2", v), 64'(tx_en_a), 64'd1);
            check($sformatf("vec%0d tx_chan", v), 64'(tx_chan_a), 64'(vecs[v].exp_chan));
            check($sformatf("vec%0d tx_data", v), 64'(tx_data_a), 64'(vecs[v].exp_data));
            check($sformatf("vec%0d busy", v), 64'(busy_a), 64'd1);
            $display("vec %0d: chan=%0d data=%h", v, tx_chan_a, tx_data_a);
            tick();
            check($sformatf("vec%0d tx_en pulse", v), 64'(tx_en_a), 64'd0);
            check($sformatf("vec%0d tx_data held", v), 64'(tx_data_a), 64'(vecs[v].exp_data));
            ack_after(vecs[v].ack_delay - 1);
            check($sformatf("vec%0d busy after ack", v), 64'(busy_a), 64'd0);
            check($sformatf("vec%0d pending after ack", v), 64'(pending_a), 64'd0);
        end

        // Coalescing: two ch2 strobes while ch0 is in flight give one transfer of 0xB.
        do_reset();
        strobe(4'b0001, pack4(48'h1, 48'h0, 48'h0, 48'h0));
        wait_tx(1'b0, "coal ch0");
        check("coal first chan", 64'(tx_chan_a), 64'd0);
        tick();
        strobe(4'b0100, pack4(48'h0, 48'h0, 48'hA, 48'h0));
        strobe(4'b0100, pack4(48'h0, 48'h0, 48'hB, 48'h0));
        check("coal pending", 64'(pending_a), 64'b0100);
        ack_after(0);
        wait_tx(1'b0, "coal ch2");
        check("coal chan", 64'(tx_chan_a), 64'd2);
        check("coal data", 64'(tx_data_a), 64'hB);
        ack_after(0);
        count_tx(12, 1'b0, cnt);
        check("coal extra transfers", 64'(cnt), 64'd0);
        check("coal pending end", 64'(pending_a), 64'd0);

        // Round robin from reset: 0,1,2,3; then with last_chan=1, ch3 before ch0.
        do_reset();
        strobe(4'b1111, pack4(48'h10, 48'h11, 48'h12, 48'h13));
        for (int k = 0; k < 4; k++) begin
            wait_tx(1'b0, "rr");
            check($sformatf("rr%0d chan", k), 64'(tx_chan_a), 64'(k));
            check($sformatf("rr%0d data", k), 64'(tx_data_a), 64'(48'h10 + k));
            ack_after(3);
        end
        strobe(4'b0010, pack4(48'h0, 48'h21, 48'h0, 48'h0));
        wait_tx(1'b0, "rr ch1");
        check("rr ch1 chan", 64'(tx_chan_a), 64'd1);
        ack_after(2);
        strobe(4'b1001, pack4(48'h30, 48'h0, 48'h0, 48'h33));
        wait_tx(1'b0, "rr second");
        check("rr after1 chan", 64'(tx_chan_a), 64'd3);
        check("rr after1 data", 64'(tx_data_a), 64'h33);
        ack_after(3);
        wait_tx(1'b0, "rr third");
        check("rr after2 chan", 64'(tx_chan_a), 64'd0);
        check("rr after2 data", 64'(tx_data_a), 64'h30);
        ack_after(3);

        // Update to the in-flight channel leaves the current transfer alone.
        do_reset();
        strobe(4'b0010, pack4(48'h0, 48'h11, 48'h0, 48'h0));
        wait_tx(1'b0, "flight first");
        check("flight first data", 64'(tx_data_a), 64'h11);
        tick();
        strobe(4'b0010, pack4(48'h0, 48'h55, 48'h0, 48'h0));
        check("flight data held", 64'(tx_data_a), 64'h11);
        check("flight chan held", 64'(tx_chan_a), 64'd1);
        check("flight pending", 64'(pending_a), 64'b0010);
        check("flight busy", 64'(busy_a), 64'd1);
        ack_after(1);
        wait_tx(1'b0, "flight second");
        check("flight second chan", 64'(tx_chan_a), 64'd1);
        check("flight second data", 64'(tx_data_a), 64'h55);
        ack_after(2);
        check("flight pending end", 64'(pending_a), 64'd0);

        // Timeout on the ACK_TIMEOUT=8 instance, then an ack on the last waiting cycle.
        do_reset();
        strobe(4'b0100, pack4(48'h0, 48'h0, 48'h77, 48'h0));
        wait_tx(1'b1, "to first");
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("to err_timeout +%0d", k), 64'(err_timeout_b), 64'(k == 8));
        end
        check("to err_count", 64'(err_count_b), 64'd1);
        check("to pending", 64'(pending_b), 64'b0100);
        check("to busy", 64'(busy_b), 64'd0);
        tick();
        check("to reissue tx_en", 64'(tx_en_b), 64'd1);
        check("to reissue chan", 64'(tx_chan_b), 64'd2);
        check("to reissue data", 64'(tx_data_b), 64'h77);
        ack_after(7);
        check("to late ack err_timeout", 64'(err_timeout_b), 64'd0);
        check("to late ack err_count", 64'(err_count_b), 64'd1);
        check("to late ack busy", 64'(busy_b), 64'd0);
        check("to late ack pending", 64'(pending_b), 64'd0);
        count_tx(10, 1'b1, cnt);
        check("to no retry", 64'(cnt), 64'd0);

        // Reset in WAIT_ACK with another update pending, then a stray ack.
        do_reset();
        strobe(4'b1000, pack4(48'h0, 48'h0, 48'h0, 48'h99));
        wait_tx(1'b0, "rst");
        tick();
        strobe(4'b0001, pack4(48'h5, 48'h0, 48'h0, 48'h0));
        check("rst busy before", 64'(busy_a), 64'd1);
        check("rst pending before", 64'(pending_a), 64'b0001);
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check("rst tx_en", 64'(tx_en_a), 64'd0);
        check("rst tx_chan", 64'(tx_chan_a), 64'd0);
        check("rst tx_data", 64'(tx_data_a), 64'd0);
        check("rst pending", 64'(pending_a), 64'd0);
        check("rst busy", 64'(busy_a), 64'd0);
        check("rst err_timeout", 64'(err_timeout_a), 64'd0);
        check("rst err_count", 64'(err_count_a), 64'd0);
        count_tx(10, 1'b0, cnt);
        check("rst no transfer", 64'(cnt), 64'd0);
        strobe(4'b0001, pack4(48'h5, 48'h0, 48'h0, 48'h0));
        tick();
        check("rst new tx_en", 64'(tx_en_a), 64'd1);
        check("rst new chan", 64'(tx_chan_a), 64'd0);
        check("rst new data", 64'(tx_data_a), 64'h5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
